regfile_writeback: RTL and testbench

- Writer side of the 32x32 register file: holds the MEM/WB pipeline register and selects the write-back value.
- Drives WriteData/WriteRegister/RegWrite into the register file write port.
- Supplies write-through bypass on both read ports, because the register file only updates on the next clock edge.
- Counts retired instructions.

---
 rtl/regfile_wb_pkg.sv | 18 +
 rtl/load_align.sv | 44 ++++
 rtl/regfile_writeback.sv | 117 +++++++++++
 tb/tb_regfile_writeback.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared constants for the register-file write-back slice.
//   Write-back select codes, load size codes and default datapath widths.
package regfile_wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Write-back value select (code 3 is reserved and behaves as ALU)
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  // Load access size (code 3 behaves as word)
  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;

endpackage

// File: rtl/load_align.sv
// load_align: big-endian byte/half/word extraction from a 32-bit memory word,
// with sign or zero extension.
//   word       in   raw data-memory word
//   off        in   byte offset within the word (address bits [1:0])
//   size       in   LD_BYTE / LD_HALF / LD_WORD (3 treated as word)
//   loadSigned in   sign-extend byte/half values
//   value      out  aligned, extended load result
module load_align
  import regfile_wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        loadSigned,
  output logic [31:0] value
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = 8'h00;
    halfSel = 16'h0000;
    value   = word;
    case (size)
      LD_BYTE: begin
        // Offset 0 addresses the most significant byte
        case (off)
          2'd0:    byteSel = word[31:24];
          2'd1:    byteSel = word[23:16];
          2'd2:    byteSel = word[15:8];
          default: byteSel = word[7:0];
        endcase
        value = {{24{loadSigned & byteSel[7]}}, byteSel};
      end
      LD_HALF: begin
        halfSel = off[1] ? word[15:0] : word[31:16];
        value   = {{16{loadSigned & halfSel[15]}}, halfSel};
      end
      default: value = word;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: MEM/WB pipeline register, write-back value select,
// register-file write port drive, write-through bypass and retire counter.
//   clk, reset (async, active-low)
//   stall, flush                  MEM/WB register control (flush wins)
//   mem_*                         MEM-stage instruction fields
//   WriteData/WriteRegister/RegWrite  register file write port
//   ReadRegister1/2, ReadData1/2  ID-stage read addresses and raw read data
//   BypData1/2                    read data with in-flight write forwarded
//   retire_count                  retired instruction count (wraps)
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic [1:0]        mem_MemtoReg,
  input  logic [1:0]        mem_LoadSize,
  input  logic              mem_LoadSigned,
  input  logic [ADDR_W-1:0] mem_WriteRegister,
  input  logic [DATA_W-1:0] mem_AluResult,
  input  logic [DATA_W-1:0] mem_ReadData,
  input  logic [DATA_W-1:0] mem_PCplus8,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] BypData1,
  output logic [DATA_W-1:0] BypData2,
  output logic [CNT_W-1:0]  retire_count
);

  logic              wbValid;
  logic              wbFresh;
  logic              wbRegWrite;
  logic [1:0]        wbMemtoReg;
  logic [1:0]        wbLoadSize;
  logic              wbLoadSigned;
  logic [ADDR_W-1:0] wbWriteRegister;
  logic [DATA_W-1:0] wbAluResult;
  logic [DATA_W-1:0] wbReadData;
  logic [DATA_W-1:0] wbPCplus8;
  logic [31:0]       loadValue;

  // wbFresh marks the first cycle an instruction sits in MEM/WB, so a stalled
  // instruction writes and retires only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbValid         <= 1'b0;
      wbFresh         <= 1'b0;
      wbRegWrite      <= 1'b0;
      wbMemtoReg      <= WB_SEL_ALU;
      wbLoadSize      <= LD_BYTE;
      wbLoadSigned    <= 1'b0;
      wbWriteRegister <= '0;
      wbAluResult     <= '0;
      wbReadData      <= '0;
      wbPCplus8       <= '0;
    end else if (flush) begin
      wbValid <= 1'b0;
      wbFresh <= 1'b0;
    end else if (stall) begin
      wbFresh <= 1'b0;
    end else begin
      wbValid         <= mem_valid;
      wbFresh         <= mem_valid;
      wbRegWrite      <= mem_RegWrite;
      wbMemtoReg      <= mem_MemtoReg;
      wbLoadSize      <= mem_LoadSize;
      wbLoadSigned    <= mem_LoadSigned;
      wbWriteRegister <= mem_WriteRegister;
      wbAluResult     <= mem_AluResult;
      wbReadData      <= mem_ReadData;
      wbPCplus8       <= mem_PCplus8;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retire_count <= '0;
    else if (wbValid && wbFresh)
      retire_count <= retire_count + CNT_W'(1);
  end

  load_align uLoadAlign (
    .word       (wbReadData),
    .off        (wbAluResult[1:0]),
    .size       (wbLoadSize),
    .loadSigned (wbLoadSigned),
    .value      (loadValue)
  );

  always_comb begin
    case (wbMemtoReg)
      WB_SEL_MEM:  WriteData = loadValue;
      WB_SEL_LINK: WriteData = wbPCplus8;
      default:     WriteData = wbAluResult;
    endcase
  end

  assign WriteRegister = wbWriteRegister;
  assign RegWrite      = wbValid & wbFresh & wbRegWrite & (wbWriteRegister != '0);

  // RegWrite already excludes r0, so an r0 read never matches a live write.
  assign BypData1 = (RegWrite && (ReadRegister1 == wbWriteRegister)) ? WriteData : ReadData1;
  assign BypData2 = (RegWrite && (ReadRegister2 == wbWriteRegister)) ? WriteData : ReadData2;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  import regfile_wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        mem_valid, mem_RegWrite, mem_LoadSigned;
  logic [1:0]  mem_MemtoReg, mem_LoadSize;
  logic [4:0]  mem_WriteRegister;
  logic [31:0] mem_AluResult, mem_ReadData, mem_PCplus8;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2;

  logic [31:0] WriteData, BypData1, BypData2, retire_count;
  logic [4:0]  WriteRegister;
  logic        RegWrite;

  logic [31:0] smWriteData, smBypData1, smBypData2;
  logic [4:0]  smWriteRegister;
  logic        smRegWrite;
  logic [3:0]  smRetire;

  int nChecks = 0;
  int nPass   = 0;
  int expRetire = 0;

  always #5 clk = ~clk;

  regfile_writeback #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_LoadSize(mem_LoadSize), .mem_LoadSigned(mem_LoadSigned),
    .mem_WriteRegister(mem_WriteRegister), .mem_AluResult(mem_AluResult),
    .mem_ReadData(mem_ReadData), .mem_PCplus8(mem_PCplus8),
    .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .BypData1(BypData1), .BypData2(BypData2), .retire_count(retire_count)
  );

  // Narrow-counter build to exercise wrap-around
  regfile_writeback #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dutSmall (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_LoadSize(mem_LoadSize), .mem_LoadSigned(mem_LoadSigned),
    .mem_WriteRegister(mem_WriteRegister), .mem_AluResult(mem_AluResult),
    .mem_ReadData(mem_ReadData), .mem_PCplus8(mem_PCplus8),
    .WriteData(smWriteData), .WriteRegister(smWriteRegister), .RegWrite(smRegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .BypData1(smBypData1), .BypData2(smBypData2), .retire_count(smRetire)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic driveOp(input logic valid, input logic rw, input logic [1:0] sel,
                         input logic [1:0] size, input logic sgn, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc8);
    stall = 1'b0; flush = 1'b0;
    mem_valid = valid; mem_RegWrite = rw; mem_MemtoReg = sel;
    mem_LoadSize = size; mem_LoadSigned = sgn; mem_WriteRegister = rd;
    mem_AluResult = alu; mem_ReadData = rdata; mem_PCplus8 = pc8;
  endtask

  task automatic bubble();
    driveOp(1'b0, 1'b0, WB_SEL_ALU, LD_WORD, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  // Drive at a negedge, then check the write port on the next negedge.
  // retire_count reflects every earlier instruction, not this one yet.
  task automatic runOp(input string tag, input logic rw, input logic [1:0] sel,
                       input logic [1:0] size, input logic sgn, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc8,
                       input logic [31:0] expWD, input logic expRW);
    driveOp(1'b1, rw, sel, size, sgn, rd, alu, rdata, pc8);
    @(negedge clk);
    checkVal({tag, ".RegWrite"}, RegWrite, expRW);
    checkVal({tag, ".WriteData"}, WriteData, expWD);
    checkVal({tag, ".WriteRegister"}, WriteRegister, rd);
    checkVal({tag, ".retire"}, retire_count, expRetire);
    checkVal({tag, ".retire4"}, smRetire, expRetire % 16);
    expRetire++;
  endtask

  initial begin
    reset = 1'b0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; ReadData1 = 32'h0; ReadData2 = 32'h0;
    bubble();
    // Inputs toggling while in reset
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      driveOp(1'b1, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1,
              5'($urandom_range(1, 31)), $urandom, $urandom, $urandom);
      stall = 1'($urandom_range(0, 1));
      checkVal("rst.RegWrite", RegWrite, 1'b0);
      checkVal("rst.WriteData", WriteData, 32'h0);
      checkVal("rst.WriteRegister", WriteRegister, 5'd0);
      checkVal("rst.retire", retire_count, 32'd0);
      checkVal("rst.retire4", smRetire, 4'd0);
    end
    @(negedge clk);
    bubble();
    reset = 1'b1;
    @(negedge clk);

    runOp("alu5", 1'b1, WB_SEL_ALU, LD_WORD, 1'b0, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678, 1'b1);
    runOp("lbs0", 1'b1, WB_SEL_MEM, LD_BYTE, 1'b1, 5'd3, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 32'hFFFF_FF80, 1'b1);
    runOp("lbu1", 1'b1, WB_SEL_MEM, LD_BYTE, 1'b0, 5'd3, 32'h0000_1001, 32'h80FF_7F01, 32'h0, 32'h0000_00FF, 1'b1);
    runOp("lbu2", 1'b1, WB_SEL_MEM, LD_BYTE, 1'b0, 5'd3, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0000_007F, 1'b1);
    runOp("lbs3", 1'b1, WB_SEL_MEM, LD_BYTE, 1'b1, 5'd3, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0000_0001, 1'b1);
    runOp("lhs2", 1'b1, WB_SEL_MEM, LD_HALF, 1'b1, 5'd4, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0000_7F01, 1'b1);
    runOp("lhs1", 1'b1, WB_SEL_MEM, LD_HALF, 1'b1, 5'd4, 32'h0000_1001, 32'h80FF_7F01, 32'h0, 32'hFFFF_80FF, 1'b1);
    runOp("lhu0", 1'b1, WB_SEL_MEM, LD_HALF, 1'b0, 5'd4, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 32'h0000_80FF, 1'b1);
    runOp("lw",   1'b1, WB_SEL_MEM, LD_WORD, 1'b1, 5'd6, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h80FF_7F01, 1'b1);
    runOp("lsz3", 1'b1, WB_SEL_MEM, 2'd3,    1'b1, 5'd6, 32'h0000_1001, 32'h80FF_7F01, 32'h0, 32'h80FF_7F01, 1'b1);
    runOp("link", 1'b1, WB_SEL_LINK, LD_WORD, 1'b0, 5'd31, 32'h0000_0004, 32'h0, 32'h0040_0010, 32'h0040_0010, 1'b1);
    runOp("linkr0", 1'b1, WB_SEL_LINK, LD_WORD, 1'b0, 5'd0, 32'h0000_0004, 32'h0, 32'h0040_0010, 32'h0040_0010, 1'b0);
    runOp("sel3", 1'b1, 2'd3, LD_WORD, 1'b0, 5'd2, 32'hCAFE_0003, 32'h1, 32'h2, 32'hCAFE_0003, 1'b1);
    runOp("norw", 1'b0, WB_SEL_ALU, LD_WORD, 1'b0, 5'd2, 32'h0BAD_0000, 32'h0, 32'h0, 32'h0BAD_0000, 1'b0);

    // Stall for 3 cycles after a write to r7: writes once, retires once
    runOp("st7", 1'b1, WB_SEL_ALU, LD_WORD, 1'b0, 5'd7, 32'h0000_0777, 32'h0, 32'h0, 32'h0000_0777, 1'b1);
    driveOp(1'b1, 1'b1, WB_SEL_ALU, LD_WORD, 1'b0, 5'd13, 32'h1313_1313, 32'h0, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("stall.RegWrite", RegWrite, 1'b0);
      checkVal("stall.WriteRegister", WriteRegister, 5'd7);
      checkVal("stall.WriteData", WriteData, 32'h0000_0777);
      checkVal("stall.retire", retire_count, expRetire);
    end
    bubble();
    @(negedge clk);
    checkVal("unstall.RegWrite", RegWrite, 1'b0);
    checkVal("unstall.retire", retire_count, expRetire);

    // Stall and flush together load a bubble
    runOp("pre8", 1'b1, WB_SEL_ALU, LD_WORD, 1'b0, 5'd8, 32'h0000_0888, 32'h0, 32'h0, 32'h0000_0888, 1'b1);
    driveOp(1'b1, 1'b1, WB_SEL_ALU, LD_WORD, 1'b0, 5'd12, 32'h1212_1212, 32'h0, 32'h0);
    stall = 1'b1; flush = 1'b1;
    @(negedge clk);
    checkVal("flush.RegWrite", RegWrite, 1'b0);
    checkVal("flush.retire", retire_count, expRetire);
    bubble();
    @(negedge clk);
    checkVal("flush2.retire", retire_count, expRetire);

    // Bypass
    ReadRegister1 = 5'd9;  ReadData1 = 32'h0;
    ReadRegister2 = 5'd10; ReadData2 = 32'h5555_AAAA;
    runOp("byp9", 1'b1, WB_SEL_ALU, LD_WORD, 1'b0, 5'd9, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    checkVal("byp.rs1hit", BypData1, 32'hDEAD_BEEF);
    checkVal("byp.rs2miss", BypData2, 32'h5555_AAAA);
    ReadRegister2 = 5'd9; #1;
    checkVal("byp.rs2hit", BypData2, 32'hDEAD_BEEF);
    ReadRegister1 = 5'd0; ReadData1 = 32'hA5A5_A5A5;
    ReadRegister2 = 5'd9; ReadData2 = 32'h0000_1111;
    runOp("bypr0", 1'b1, WB_SEL_ALU, LD_WORD, 1'b0, 5'd0, 32'h7777_7777, 32'h0, 32'h0, 32'h7777_7777, 1'b0);
    checkVal("byp.r0", BypData1, 32'hA5A5_A5A5);
    checkVal("byp.nowrite", BypData2, 32'h0000_1111);

    // Enough retirements to carry the narrow counter past its wrap point
    for (int i = 0; i < 8; i++)
      runOp("wrap", 1'b1, WB_SEL_ALU, LD_WORD, 1'b0, 5'(i + 1), 32'(i * 3), 32'h0, 32'h0, 32'(i * 3), 1'b1);
    bubble();
    @(negedge clk);
    checkVal("wrap.final", retire_count, expRetire);
    checkVal("wrap.final4", smRetire, expRetire % 16);

    // Reset during an active write drops it immediately
    driveOp(1'b1, 1'b1, WB_SEL_ALU, LD_WORD, 1'b0, 5'd4, 32'h0000_0044, 32'h0, 32'h0);
    @(posedge clk); #1;
    bubble();
    checkVal("mrst.pre", RegWrite, 1'b1);
    #1 reset = 1'b0;
    #1;
    checkVal("mrst.RegWrite", RegWrite, 1'b0);
    checkVal("mrst.WriteData", WriteData, 32'h0);
    checkVal("mrst.retire", retire_count, 32'd0);
    checkVal("mrst.retire4", smRetire, 4'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
